// File: rtl/rv32i_fetch.sv
// RV32I instruction fetch stage: PC register, IF/ID pipeline register and a
// small BOOT/RUN/HALT controller. Redirects come from MEM via PCsrc and flush
// IF/ID; ecall/ebreak park the fetch unit until a redirect or reset.
module rv32i_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        PCsrc,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] PC_OUT_if,
  output logic [31:0] instr_id,
  output logic [31:0] pc_id,
  output logic [31:0] pc_plus4_id,
  output logic        valid_id,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcid_q, pcid_d;
  logic [31:0] p4_q, p4_d;
  logic        valid_q, valid_d;
  logic        merr_q, merr_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic        bubble, redirect, advance;
  logic [31:0] pc_plus4;
  logic        is_sys;
  logic        aligned;

  assign pc_plus4 = pc_q + 32'd4;
  assign is_sys   = (imem_rdata == ECALL) || (imem_rdata == EBREAK);
  assign aligned  = (branch_target[1:0] == 2'b00);

  // State, PC and IF/ID registers; reset clears everything immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      pcid_q        <= 32'd0;
      p4_q          <= 32'd0;
      valid_q       <= 1'b0;
      merr_q        <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pcid_q        <= pcid_d;
      p4_q          <= p4_d;
      valid_q       <= valid_d;
      merr_q        <= merr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Next-state: pick one action per edge (redirect > stall > advance), then apply it.
  // A halt caused by a misaligned target is fatal: merr_q blocks redirects out of it.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    pcid_d        = pcid_q;
    p4_d          = p4_q;
    valid_d       = valid_q;
    merr_d        = merr_q;
    fetch_count_d = fetch_count_q;
    bubble        = 1'b0;
    redirect      = 1'b0;
    advance       = 1'b0;

    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN: begin
        if (PCsrc)       redirect = 1'b1;
        else if (!stall) advance  = 1'b1;
      end
      S_HALT: begin
        if (PCsrc && !merr_q) redirect = 1'b1;
        else                  bubble   = 1'b1;
      end
      default: state_d = S_BOOT;
    endcase

    if (redirect) begin
      bubble = 1'b1;
      if (aligned) begin
        pc_d    = branch_target;
        state_d = S_RUN;
      end else begin
        merr_d  = 1'b1;
        state_d = S_HALT;
      end
    end

    if (bubble) begin
      instr_d = NOP_INSTR;
      pcid_d  = 32'd0;
      p4_d    = 32'd0;
      valid_d = 1'b0;
    end

    if (advance) begin
      instr_d       = imem_rdata;
      pcid_d        = pc_q;
      p4_d          = pc_plus4;
      valid_d       = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
      // System instruction parks the PC on its own address
      if (is_sys) state_d = S_HALT;
      else        pc_d    = pc_plus4;
    end
  end

  assign imem_addr    = pc_q;
  assign PC_OUT_if    = pc_q;
  assign instr_id     = instr_q;
  assign pc_id        = pcid_q;
  assign pc_plus4_id  = p4_q;
  assign valid_id     = valid_q;
  assign halted       = (state_q == S_HALT);
  assign misalign_err = merr_q;
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_rv32i_fetch.sv
// Bench for rv32i_fetch: directed scenarios followed by a randomized run,
// all compared against a cycle-level behavioural model of the fetch stage.
module tb_rv32i_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        PCsrc;
  logic [31:0] branch_target;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] PC_OUT_if;
  logic [31:0] instr_id;
  logic [31:0] pc_id;
  logic [31:0] pc_plus4_id;
  logic        valid_id;
  logic        halted;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  rv32i_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .PCsrc(PCsrc),
    .branch_target(branch_target), .imem_rdata(imem_rdata),
    .imem_addr(imem_addr), .PC_OUT_if(PC_OUT_if), .instr_id(instr_id),
    .pc_id(pc_id), .pc_plus4_id(pc_plus4_id), .valid_id(valid_id),
    .halted(halted), .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory contents
  bit          mode_const;
  logic [31:0] imem [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mode_const)      return 32'h0050_0093;
    if (imem.exists(a))  return imem[a];
    return {a[19:0], 12'h093};
  endfunction

  // Behavioural model of the fetch stage
  logic [31:0] m_pc, m_ir, m_pcid, m_p4, m_cnt;
  bit          m_v, m_halt, m_fatal, m_merr, m_boot;

  task automatic m_reset();
    m_pc = 32'h0; m_ir = 32'h13; m_pcid = 0; m_p4 = 0; m_cnt = 0;
    m_v = 0; m_halt = 0; m_fatal = 0; m_merr = 0; m_boot = 1;
  endtask

  task automatic m_bubble();
    m_ir = 32'h13; m_pcid = 0; m_p4 = 0; m_v = 0;
  endtask

  task automatic m_edge(input bit st, input bit pcs, input logic [31:0] bt);
    logic [31:0] w;
    w = mem_word(m_pc);
    if (m_boot) m_boot = 0;
    else if (m_halt && (m_fatal || !pcs)) m_bubble();
    else if (pcs) begin
      m_bubble();
      if (bt % 4 == 0) begin m_pc = bt; m_halt = 0; end
      else begin m_merr = 1; m_fatal = 1; m_halt = 1; end
    end else if (!st) begin
      m_ir = w; m_pcid = m_pc; m_p4 = m_pc + 4; m_v = 1; m_cnt = m_cnt + 1;
      if (w == 32'h73 || w == 32'h0010_0073) m_halt = 1;
      else m_pc = m_pc + 4;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc",        PC_OUT_if,           m_pc);
    chk("imem_addr", imem_addr,           m_pc);
    chk("instr_id",  instr_id,            m_ir);
    chk("pc_id",     pc_id,               m_pcid);
    chk("pc4_id",    pc_plus4_id,         m_p4);
    chk("valid_id",  {31'd0, valid_id},   {31'd0, m_v});
    chk("halted",    {31'd0, halted},     {31'd0, m_halt});
    chk("misalign",  {31'd0, misalign_err}, {31'd0, m_merr});
    chk("count",     fetch_count,         m_cnt);
  endtask

  // Called at a negedge: apply inputs, clock once, compare, return at next negedge
  task automatic step(input bit st, input bit pcs, input logic [31:0] bt);
    stall = st; PCsrc = pcs; branch_target = bt;
    imem_rdata = mem_word(imem_addr);
    m_edge(st, pcs, bt);
    @(posedge clk); #1;
    check_all();
    @(negedge clk);
  endtask

  // Asynchronous reset pulse; state is checked before any clock edge
  task automatic do_reset();
    reset = 1; stall = 1; PCsrc = 1; branch_target = 32'h44;
    m_reset();
    #1 check_all();
    @(posedge clk); #1 check_all();
    @(negedge clk);
    reset = 0; stall = 0; PCsrc = 0;
  endtask

  initial begin
    reset = 1; stall = 0; PCsrc = 0; branch_target = 0; imem_rdata = 0;
    mode_const = 1;
    @(negedge clk);
    do_reset();

    // Straight-line fetch: BOOT then 10 advances
    step(0, 0, 0);
    chk("boot_pc", PC_OUT_if, 32'h0);
    step(0, 0, 0);
    chk("first_instr", instr_id, 32'h0050_0093);
    chk("first_pc4", PC_OUT_if, 32'h4);
    for (int i = 0; i < 9; i++) step(0, 0, 0);
    chk("count10", fetch_count, 32'd10);

    // Stall for three cycles at PC 0x10 (reset applied mid-run)
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    chk("pc_0x10", PC_OUT_if, 32'h10);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    chk("stall_pc", PC_OUT_if, 32'h10);
    chk("stall_cnt", fetch_count, 32'd4);
    step(0, 0, 0);
    chk("unstall_pcid", pc_id, 32'h10);

    // Redirect beats stall at PC 0x20
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("pc_0x20", PC_OUT_if, 32'h20);
    step(1, 1, 32'h40);
    chk("redir_pc", PC_OUT_if, 32'h40);
    chk("redir_nop", instr_id, 32'h13);
    step(0, 0, 0);
    chk("redir_pcid", pc_id, 32'h40);

    // ebreak at 0x08, then a wrong-path recovery redirect
    mode_const = 0;
    imem.delete();
    imem[32'h8] = 32'h0010_0073;
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    chk("ebreak_instr", instr_id, 32'h0010_0073);
    chk("ebreak_halt", {31'd0, halted}, 32'd1);
    chk("ebreak_pc", PC_OUT_if, 32'h8);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("halt_bubble", {31'd0, valid_id}, 32'd0);
    step(0, 1, 32'h100);
    chk("resume_pc", PC_OUT_if, 32'h100);
    step(0, 0, 0);

    // Misaligned target halts for good; reset clears it
    step(0, 1, 32'h42);
    chk("merr_set", {31'd0, misalign_err}, 32'd1);
    step(0, 1, 32'h80);
    chk("merr_ignore", PC_OUT_if, 32'h104);
    step(0, 0, 0);
    do_reset();
    chk("merr_clr", {31'd0, misalign_err}, 32'd0);

    // Counter and PC wraparound
    step(0, 0, 0);
    step(0, 1, 32'hFFFF_FFFC);
    force dut.fetch_count_q = 32'hFFFF_FFFF;
    #1 release dut.fetch_count_q;
    m_cnt = 32'hFFFF_FFFF;
    step(0, 0, 0);
    chk("cnt_wrap", fetch_count, 32'h0);
    chk("pc_wrap", PC_OUT_if, 32'h0);

    // Randomized traffic with a few system instructions sprinkled in
    imem.delete();
    for (int i = 0; i < 4; i++)
      imem[{22'd0, 8'($urandom_range(4, 63)), 2'b00}] =
        ($urandom_range(0, 1) != 0) ? 32'h73 : 32'h0010_0073;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      tgt = {22'd0, 8'($urandom_range(0, 63)), 2'b00};
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, tgt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
